// File: rtl/ram_master.sv
// Burst controller for a small asynchronous-read RAM with wr/rd strobes.
// Commands, write beats and read beats all use valid/ready handshakes.
module ram_master #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] beats_left_q, beats_left_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              cmd_fire, wr_fire, slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cur_addr_q    <= '0;
            beats_left_q  <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            beats_left_q  <= beats_left_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign wr_fire   = wdata_valid & wdata_ready;
    assign slot_free = ~rdata_valid_q | rdata_ready;

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        beats_left_d  = beats_left_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        mem_wr_d      = 1'b0;
        mem_rd_d      = mem_rd_q;
        // A consumed beat frees the slot unless a new capture refills it below.
        rdata_valid_d = rdata_valid_q & ~rdata_ready;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    cur_addr_d   = cmd_addr;
                    beats_left_d = cmd_len;
                    if (cmd_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d    = StRead;
                        mem_addr_d = cmd_addr;
                        mem_rd_d   = 1'b1;
                    end
                end
            end
            StWrite: begin
                if (wr_fire) begin
                    mem_addr_d   = cur_addr_q;
                    mem_wdata_d  = wdata;
                    mem_wr_d     = 1'b1;
                    cur_addr_d   = cur_addr_q + ADDR_W'(1);
                    beats_left_d = beats_left_q - ADDR_W'(1);
                    if (beats_left_q == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                if (slot_free) begin
                    rdata_d       = mem_rdata;
                    rdata_valid_d = 1'b1;
                    mem_addr_d    = mem_addr_q + ADDR_W'(1);
                    beats_left_d  = beats_left_q - ADDR_W'(1);
                    if (beats_left_q == '0) begin
                        mem_rd_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding off new commands until the write strobe drops keeps wr and rd exclusive.
    always_comb begin
        cmd_ready   = (state_q == StIdle) & ~rdata_valid_q & ~mem_wr_q;
        wdata_ready = (state_q == StWrite);
        busy        = (state_q != StIdle);
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule
